lc3_mem_arbiter: RTL and testbench
==================================

// Module: lc3_mem_arbiter
// PURPOSE
//   Shares one single-ported LC3 memory between the fetch requester (pc/instrmem_rd) and the data
//   requester (Data_addr/Data_din/Data_rd), returning Instr_dout/complete_instr and Data_dout/complete_data.
//   Sits between the LC3 core and the memory model. Data has priority with a fetch anti-starvation guard.
//   A per-access timeout converts a hung memory into an error completion.
// PARAMETERS
//   MAX_DATA_STREAK  4   consecutive data grants allowed while fetch is pending (1..15)
//   TIMEOUT          16  cycles in BUSY without mem_ready before error completion (2..255)
// PORTS
//   clock           in   1   single clock, all state on posedge
//   reset           in   1   asynchronous, active-low; asserted (0) clears all state immediately
//   instrmem_rd     in   1   fetch request, level, held until complete_instr
//   pc              in   16  fetch address
//   Instr_dout      out  16  fetched instruction, valid when complete_instr=1, held until next fetch completion
//   complete_instr  out  1   one-cycle fetch completion pulse
//   data_req        in   1   data request, level, held until complete_data
//   Data_rd         in   1   1=read, 0=write; sampled at grant
//   Data_addr       in   16  data address
//   Data_din        in   16  write data
//   Data_dout       out  16  read data, valid when complete_data=1, held until next data read completion
//   complete_data   out  1   one-cycle data completion pulse (reads and writes)
//   mem_req         out  1   memory access request, held until mem_ready or timeout
//   mem_we          out  1   1=write access
//   mem_addr        out  16  latched access address
//   mem_wdata       out  16  latched write data
//   mem_rdata       in   16  read data, valid with mem_ready
//   mem_ready       in   1   access done; sampled only while mem_req=1
//   bus_err         out  1   sticky timeout flag; cleared only by reset
// BEHAVIOUR
//   Reset (reset=0): state IDLE; all outputs 0 (Instr_dout, Data_dout, mem_addr, mem_wdata = 16'h0000);
//     streak and timeout counters 0. Reset mid-access abandons it: no completion pulse afterwards.
//   States: IDLE, BUSY_I, BUSY_D, RESP. All outputs registered.
//   IDLE: at edge with data_req=1 and (instrmem_rd=0 or streak<MAX_DATA_STREAK) -> BUSY_D, latch Data_addr,
//     Data_din, mem_we=~Data_rd; else if instrmem_rd=1 -> BUSY_I, latch pc, mem_we=0. mem_req=1 from next cycle.
//     No request -> stay IDLE.
//   Streak: on data grant with instrmem_rd=1 -> streak+1 (saturate); on data grant with instrmem_rd=0 -> 0;
//     on fetch grant -> 0.
//   BUSY_x: edge with mem_ready=1 -> mem_req=0, mem_we=0, capture mem_rdata into Instr_dout (BUSY_I) or Data_dout
//     (BUSY_D read only; writes leave Data_dout unchanged), pulse matching complete_* for 1 cycle, -> RESP.
//   Timeout: counter increments each BUSY cycle without mem_ready, cleared on grant; at count == TIMEOUT-1
//     without mem_ready -> mem_req=0, bus_err=1, complete_* pulsed, captured dout = 16'h0000, -> RESP.
//     mem_ready and timeout on same edge: mem_ready wins, no error.
//   RESP: complete_* high this cycle; requests ignored; next edge -> IDLE. Requester drops its level by that edge.
//   Min latency: req sampled edge N, mem_req high N..N+1, mem_ready at N+1 -> complete at N+1, IDLE at N+2.
//   Only one access outstanding; complete_instr and complete_data never both 1.
//   Requester changing address/Rd while holding request: ignored after grant (values latched).
// TESTING
//   Single fetch pc=16'h3000, mem_ready 1 cycle later with 16'h1234 -> one complete_instr pulse, Instr_dout=16'h1234.
//   Data write Data_rd=0 addr=16'h4000 din=16'hBEEF -> mem_we=1, mem_wdata=16'hBEEF, complete_data pulse, Data_dout unchanged.
//   Fetch and data requested same edge -> data granted first, fetch granted on next IDLE.
//   Continuous data requests + pending fetch, MAX_DATA_STREAK=4 -> 4 data grants then 1 fetch grant, repeat.
//   mem_ready never asserted, TIMEOUT=16 -> complete pulse 16 cycles after mem_req rise, dout=0, bus_err=1 stays set.
//   reset=0 mid BUSY_D -> outputs 0 immediately, no completion; after release, fresh fetch completes normally.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// ============================================================================
// Module  : lc3_mem_arbiter
// Brief   : Arbitrates one single-ported LC3 memory between instruction fetch
//           and data requesters; data has priority, fetch has a streak guard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_mem_arbiter #(
    parameter int MAX_DATA_STREAK = 4,
    parameter int TIMEOUT         = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instrmem_rd,
    input  logic [15:0] pc,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    input  logic        data_req,
    input  logic        Data_rd,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    output logic [15:0] Data_dout,
    output logic        complete_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY_I = 2'd1;
    localparam logic [1:0] c_BUSY_D = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    localparam logic [3:0] c_STREAK_MAX = 4'(MAX_DATA_STREAK);
    localparam logic [7:0] c_TMO_LAST   = 8'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] instr_dout_q, instr_dout_d;
    logic [15:0] data_dout_q, data_dout_d;
    logic        cmp_i_q, cmp_i_d;
    logic        cmp_d_q, cmp_d_d;
    logic        bus_err_q, bus_err_d;

    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_timeout;
    logic        w_busy;

    // Data wins unless a waiting fetch has already been passed over too often.
    assign w_grant_d = data_req && (!instrmem_rd || (streak_q < c_STREAK_MAX));
    assign w_grant_i = !w_grant_d && instrmem_rd;
    assign w_busy    = (state_q == c_BUSY_I) || (state_q == c_BUSY_D);
    assign w_timeout = !mem_ready && (tmo_q == c_TMO_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= c_IDLE;
            streak_q     <= 4'd0;
            tmo_q        <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 16'h0000;
            instr_dout_q <= 16'h0000;
            data_dout_q  <= 16'h0000;
            cmp_i_q      <= 1'b0;
            cmp_d_q      <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            tmo_q        <= tmo_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            instr_dout_q <= instr_dout_d;
            data_dout_q  <= data_dout_d;
            cmp_i_q      <= cmp_i_d;
            cmp_d_q      <= cmp_d_d;
            bus_err_q    <= bus_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_grant_d) begin
                    state_d = c_BUSY_D;
                end else if (w_grant_i) begin
                    state_d = c_BUSY_I;
                end
            end
            c_BUSY_I, c_BUSY_D: begin
                if (mem_ready || w_timeout) begin
                    state_d = c_RESP;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        streak_d     = streak_q;
        tmo_d        = tmo_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        instr_dout_d = instr_dout_q;
        data_dout_d  = data_dout_q;
        cmp_i_d      = 1'b0;
        cmp_d_d      = 1'b0;
        bus_err_d    = bus_err_q;

        if (state_q == c_IDLE) begin
            if (w_grant_d) begin
                mem_req_d   = 1'b1;
                mem_we_d    = !Data_rd;
                mem_addr_d  = Data_addr;
                mem_wdata_d = Data_din;
                tmo_d       = 8'd0;
                if (!instrmem_rd) begin
                    streak_d = 4'd0;
                end else if (streak_q != 4'hF) begin
                    streak_d = streak_q + 4'd1;
                end
            end else if (w_grant_i) begin
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = pc;
                tmo_d      = 8'd0;
                streak_d   = 4'd0;
            end
        end else if (w_busy) begin
            if (mem_ready || w_timeout) begin
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
                if (!mem_ready) begin
                    bus_err_d = 1'b1;
                end
                // A timed-out read returns zero; writes never touch Data_dout.
                if (state_q == c_BUSY_I) begin
                    cmp_i_d      = 1'b1;
                    instr_dout_d = mem_ready ? mem_rdata : 16'h0000;
                end else begin
                    cmp_d_d = 1'b1;
                    if (!mem_we_q) begin
                        data_dout_d = mem_ready ? mem_rdata : 16'h0000;
                    end
                end
            end else begin
                tmo_d = tmo_q + 8'd1;
            end
        end
    end

    assign Instr_dout     = instr_dout_q;
    assign complete_instr = cmp_i_q;
    assign Data_dout      = data_dout_q;
    assign complete_data  = cmp_d_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign bus_err        = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_lc3_mem_arbiter.sv
// ============================================================================
// Module  : tb_lc3_mem_arbiter
// Brief   : Self-checking bench for lc3_mem_arbiter against a transaction model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3_mem_arbiter;

    localparam int MDS = 4;
    localparam int TO  = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        instrmem_rd, data_req, Data_rd, mem_ready;
    logic [15:0] pc, Data_addr, Data_din, mem_rdata;
    logic [15:0] Instr_dout, Data_dout, mem_addr, mem_wdata;
    logic        complete_instr, complete_data, mem_req, mem_we, bus_err;

    lc3_mem_arbiter #(.MAX_DATA_STREAK(MDS), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .instrmem_rd(instrmem_rd), .pc(pc),
        .Instr_dout(Instr_dout), .complete_instr(complete_instr),
        .data_req(data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
        .Data_dout(Data_dout), .complete_data(complete_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Requester and transaction-model state
    bit          f_pend, d_pend;
    int          f_done = -10, d_done = -10;
    int          e = 0;
    int          free_at = 0;
    int          streak = 0;
    bit          busy = 0;
    int          g_edge, c_edge, lat;
    bit          g_is_d, g_we, g_to;
    logic [15:0] g_addr, g_wdata;
    logic [15:0] exp_i = 16'h0, exp_d = 16'h0;
    bit          exp_err = 0;
    int          force_lat = 0;
    int          p_f = 0, p_d = 0;
    bit          rand_vals = 0;
    int          n_grant_d = 0, n_grant_i = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, expv, e);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, obs, expv, e);
        end
    endtask

    // One clock edge: drive requesters and memory, advance the model, check outputs.
    task automatic step();
        bit exp_req, exp_ci, exp_cd, exp_we;
        if (rand_vals) begin
            if (!f_pend && e > f_done + 1 && int'($urandom_range(99)) < p_f) f_pend = 1;
            if (!d_pend && e > d_done + 1 && int'($urandom_range(99)) < p_d) d_pend = 1;
            if (f_pend) pc = 16'($urandom);
            if (d_pend) begin
                Data_addr = 16'($urandom);
                Data_din  = 16'($urandom);
                Data_rd   = 1'($urandom);
            end
            mem_rdata = 16'($urandom);
        end
        instrmem_rd = f_pend;
        data_req    = d_pend;
        mem_ready   = busy ? (e == g_edge + lat) : ($urandom_range(3) == 0);

        if (!busy && e >= free_at && (d_pend || f_pend)) begin
            g_is_d = d_pend && (!f_pend || streak < MDS);
            if (g_is_d) begin
                streak = f_pend ? ((streak < 15) ? streak + 1 : 15) : 0;
                n_grant_d++;
            end else begin
                streak = 0;
                n_grant_i++;
            end
            g_we   = g_is_d && !Data_rd;
            g_addr = g_is_d ? Data_addr : pc;
            if (g_we) g_wdata = Data_din;
            lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 20));
            if (g_we && lat > TO) lat = TO;
            g_to    = lat > TO;
            g_edge  = e;
            c_edge  = e + (g_to ? TO : lat);
            free_at = c_edge + 2;
            busy    = 1;
        end
        if (busy && e == c_edge) begin
            if (g_to) exp_err = 1;
            if (!g_is_d) exp_i = g_to ? 16'h0 : mem_rdata;
            else if (!g_we) exp_d = g_to ? 16'h0 : mem_rdata;
        end

        @(posedge clock);
        #1;
        exp_req = busy && e < c_edge;
        exp_we  = exp_req && g_we;
        exp_ci  = busy && e == c_edge && !g_is_d;
        exp_cd  = busy && e == c_edge && g_is_d;
        chk1("mem_req", mem_req, exp_req);
        chk1("mem_we", mem_we, exp_we);
        chk1("complete_instr", complete_instr, exp_ci);
        chk1("complete_data", complete_data, exp_cd);
        chk1("bus_err", bus_err, exp_err);
        chk("Instr_dout", Instr_dout, exp_i);
        chk("Data_dout", Data_dout, exp_d);
        if (busy && e == g_edge) begin
            chk("mem_addr", mem_addr, g_addr);
            if (g_we) chk("mem_wdata", mem_wdata, g_wdata);
        end
        if (busy && e == c_edge) begin
            busy = 0;
            if (g_is_d) begin d_pend = 0; d_done = e; end
            else        begin f_pend = 0; f_done = e; end
            instrmem_rd = f_pend;
            data_req    = d_pend;
        end
        e++;
    endtask

    initial begin
        reset = 1'b0;
        instrmem_rd = 0; data_req = 0; Data_rd = 1; mem_ready = 0;
        pc = 16'h0; Data_addr = 16'h0; Data_din = 16'h0; mem_rdata = 16'h0;
        repeat (2) @(posedge clock);
        #1;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_cmp_i", complete_instr, 1'b0);
        chk1("rst_cmp_d", complete_data, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0);
        chk("rst_mem_wdata", mem_wdata, 16'h0);
        chk("rst_Instr_dout", Instr_dout, 16'h0);
        chk("rst_Data_dout", Data_dout, 16'h0);
        reset = 1'b1;

        // Single fetch, one-cycle memory
        pc = 16'h3000; mem_rdata = 16'h1234; f_pend = 1; force_lat = 1;
        repeat (4) step();
        chk("fetch_3000_dout", Instr_dout, 16'h1234);

        // Data write leaves Data_dout alone
        Data_rd = 0; Data_addr = 16'h4000; Data_din = 16'hBEEF; d_pend = 1;
        repeat (4) step();
        chk("write_wdata", mem_wdata, 16'hBEEF);
        chk("write_addr", mem_addr, 16'h4000);
        chk("write_dout_kept", Data_dout, 16'h0000);

        // Simultaneous fetch and data read: data first
        pc = 16'h5000; Data_addr = 16'h6000; Data_rd = 1; mem_rdata = 16'hABCD;
        f_pend = 1; d_pend = 1;
        repeat (8) step();
        chk("both_data_dout", Data_dout, 16'hABCD);
        chk("both_instr_last_addr", mem_addr, 16'h5000);

        // Continuous data pressure with a waiting fetch
        n_grant_d = 0; n_grant_i = 0;
        rand_vals = 1; p_f = 100; p_d = 100;
        repeat (60) step();
        p_f = 0; p_d = 0;
        repeat (10) step();
        chk1("streak_fetch_progress", n_grant_i > 0, 1'b1);

        // Hung memory on a fetch
        rand_vals = 0; force_lat = 100; pc = 16'h3100; f_pend = 1;
        repeat (20) step();
        chk1("timeout_bus_err", bus_err, 1'b1);
        chk("timeout_dout", Instr_dout, 16'h0000);

        // Reset in the middle of a data read
        Data_rd = 1; Data_addr = 16'h2222; d_pend = 1;
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        chk1("midrst_mem_req", mem_req, 1'b0);
        chk1("midrst_bus_err", bus_err, 1'b0);
        chk1("midrst_cmp_d", complete_data, 1'b0);
        chk("midrst_mem_addr", mem_addr, 16'h0);
        chk("midrst_Instr_dout", Instr_dout, 16'h0);
        busy = 0; f_pend = 0; d_pend = 0; streak = 0;
        exp_i = 16'h0; exp_d = 16'h0; exp_err = 0;
        f_done = -10; d_done = -10;
        instrmem_rd = 0; data_req = 0;
        @(posedge clock);
        #1;
        e++;
        chk1("midrst_no_cmp", complete_data, 1'b0);
        chk1("midrst_still_idle", mem_req, 1'b0);
        reset = 1'b1;
        free_at = e;
        pc = 16'h7000; mem_rdata = 16'h55AA; force_lat = 2; f_pend = 1;
        repeat (6) step();
        chk("after_rst_fetch", Instr_dout, 16'h55AA);

        // Randomized traffic with random latencies and timeouts
        force_lat = 0; rand_vals = 1; p_f = 30; p_d = 30;
        repeat (2000) step();
        p_f = 0; p_d = 0;
        repeat (40) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
